// File: rtl/serial_pattern_detector_if.sv
// Serial bit-stream input and detector results, bundled for the pattern detector.
// master drives the stream and clear; slave is the detector.
interface serial_pattern_detector_if #(
    parameter int PAT_LEN   = 4,
    parameter int CNT_WIDTH = 8
);
    logic                 d;
    logic                 dValid;
    logic                 clear;
    logic [PAT_LEN-1:0]   shiftOut;
    logic                 match;
    logic [CNT_WIDTH-1:0] matchCount;
    logic                 countSat;

    modport master (
        output d, dValid, clear,
        input  shiftOut, match, matchCount, countSat
    );

    modport slave (
        input  d, dValid, clear,
        output shiftOut, match, matchCount, countSat
    );
endinterface

// File: rtl/serial_pattern_detector.sv
// Shifts accepted serial bits into a PAT_LEN register, pulses match on each PATTERN hit, counts hits (saturating).
// Latency: match/shiftOut/matchCount update at the edge that accepts the completing bit; all outputs registered.
// Backpressure: none; bits are taken only when dValid is high, otherwise the stream is ignored and state holds.
module serial_pattern_detector #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1011,
    parameter bit                 OVERLAP   = 1'b1,
    parameter int                 CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    resetBar,
    serial_pattern_detector_if.slave bus
);
    localparam int                   FILL_W  = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]    FULL    = FILL_W'(PAT_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    // The state is a decode of the fill level; it is kept registered so the
    // accept path can use it directly instead of re-comparing fill.
    function automatic state_t state_of(input logic [FILL_W-1:0] f);
        if (f == '0) begin
            return EMPTY;
        end else if (f == FULL) begin
            return ARMED;
        end else begin
            return FILLING;
        end
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic [FILL_W-1:0]    fill_cnt;
    logic [FILL_W-1:0]    fill_nxt;
    logic [PAT_LEN-1:0]   shift_reg;
    logic [PAT_LEN-1:0]   shift_nxt;
    logic                 match_reg;
    logic                 match_nxt;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_nxt;

    logic [PAT_LEN-1:0]   shift_acc;
    logic [FILL_W-1:0]    fill_acc;
    logic                 hit;

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state     <= EMPTY;
            fill_cnt  <= '0;
            shift_reg <= '0;
            match_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            shift_reg <= shift_nxt;
            match_reg <= match_nxt;
            count_reg <= count_nxt;
        end
    end

    always_comb begin
        shift_nxt = shift_reg;
        fill_nxt  = fill_cnt;
        match_nxt = 1'b0;
        count_nxt = count_reg;

        // Candidate contents if the current bit is accepted.
        shift_acc = {shift_reg[PAT_LEN-2:0], bus.d};
        fill_acc  = (state == ARMED) ? FULL : fill_cnt + FILL_W'(1);
        hit       = (shift_acc == PATTERN) && (fill_acc == FULL);

        if (bus.clear) begin
            shift_nxt = '0;
            fill_nxt  = '0;
            count_nxt = '0;
        end else if (bus.dValid) begin
            shift_nxt = shift_acc;
            match_nxt = hit;
            // Without overlap, bits of a completed pattern may not start the next one.
            fill_nxt  = (hit && !OVERLAP) ? '0 : fill_acc;
            if (hit && (count_reg != CNT_MAX)) begin
                count_nxt = count_reg + CNT_WIDTH'(1);
            end
        end

        state_nxt = state_of(fill_nxt);
    end

    assign bus.shiftOut   = shift_reg;
    assign bus.match      = match_reg;
    assign bus.matchCount = count_reg;
    assign bus.countSat   = (count_reg == CNT_MAX);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: an overlapping 8-bit-count instance and a non-overlapping
// 2-bit-count instance share one directed stimulus stream and are checked against a history-based model.
module tb_serial_pattern_detector;
    localparam int PAT_LEN = 4;

    logic clk;
    logic resetBar;
    logic d;
    logic dValid;
    logic clear;

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    serial_pattern_detector_if #(.PAT_LEN(PAT_LEN), .CNT_WIDTH(8)) if_ov ();
    serial_pattern_detector_if #(.PAT_LEN(PAT_LEN), .CNT_WIDTH(2)) if_no ();

    assign if_ov.d      = d;
    assign if_ov.dValid = dValid;
    assign if_ov.clear  = clear;
    assign if_no.d      = d;
    assign if_no.dValid = dValid;
    assign if_no.clear  = clear;

    serial_pattern_detector #(
        .PAT_LEN(PAT_LEN), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_WIDTH(8)
    ) dut_ov (
        .clk(clk), .resetBar(resetBar), .bus(if_ov)
    );

    serial_pattern_detector #(
        .PAT_LEN(PAT_LEN), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_WIDTH(2)
    ) dut_no (
        .clk(clk), .resetBar(resetBar), .bus(if_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of accepted bits since reset/clear, plus per-instance bit budget since last restart.
    bit hist[$];
    int m_avail[2] = '{0, 0};
    int m_match[2] = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_max[2]   = '{255, 3};
    bit m_ovl[2]   = '{1'b1, 1'b0};
    bit pat_bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    function automatic int last_bits();
        int v = 0;
        for (int i = 0; i < PAT_LEN; i++) begin
            int idx = hist.size() - PAT_LEN + i;
            v = (v << 1) | ((idx >= 0) ? int'(hist[idx]) : 0);
        end
        return v;
    endfunction

    function automatic bit tail_is_pattern();
        if (hist.size() < PAT_LEN) return 1'b0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (hist[hist.size() - PAT_LEN + i] != pat_bits[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 2; k++) begin
            m_avail[k] = 0;
            m_match[k] = 0;
            m_cnt[k]   = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge resetBar);
            if (!resetBar) begin
                model_reset();
            end else if (clear) begin
                model_reset();
            end else if (dValid) begin
                hist.push_back(d);
                if (hist.size() > 16) void'(hist.pop_front());
                for (int k = 0; k < 2; k++) begin
                    m_avail[k]++;
                    m_match[k] = (m_avail[k] >= PAT_LEN && tail_is_pattern()) ? 1 : 0;
                    if (m_match[k] != 0) begin
                        if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                        if (!m_ovl[k]) m_avail[k] = 0;
                    end
                end
            end else begin
                m_match[0] = 0;
                m_match[1] = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                chk("ov_shiftOut",   int'(if_ov.shiftOut),   last_bits());
                chk("ov_match",      int'(if_ov.match),      m_match[0]);
                chk("ov_matchCount", int'(if_ov.matchCount), m_cnt[0]);
                chk("ov_countSat",   int'(if_ov.countSat),   (m_cnt[0] == m_max[0]) ? 1 : 0);
                chk("no_shiftOut",   int'(if_no.shiftOut),   last_bits());
                chk("no_match",      int'(if_no.match),      m_match[1]);
                chk("no_matchCount", int'(if_no.matchCount), m_cnt[1]);
                chk("no_countSat",   int'(if_no.countSat),   (m_cnt[1] == m_max[1]) ? 1 : 0);
            end
        end
    end

    task automatic bit_in(input bit b);
        d      = b;
        dValid = 1'b1;
        clear  = 1'b0;
        @(negedge clk);
        dValid = 1'b0;
    endtask

    task automatic bits_in(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            d      = ~d;
            dValid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_clear(input bit dv, input bit db);
        clear  = 1'b1;
        dValid = dv;
        d      = db;
        @(negedge clk);
        clear  = 1'b0;
        dValid = 1'b0;
    endtask

    int pulses;

    initial begin
        resetBar = 1'b0;
        d        = 1'b0;
        dValid   = 1'b0;
        clear    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_shiftOut", int'(if_ov.shiftOut), 0);
        chk("rst_match", int'(if_ov.match), 0);
        chk("rst_matchCount", int'(if_no.matchCount), 0);
        chk("rst_countSat", int'(if_no.countSat), 0);
        run      = 1'b1;
        resetBar = 1'b1;

        // Basic detection of 1,0,1,1.
        bits_in(16'b1011, 4);
        chk("t1_match", int'(if_ov.match), 1);
        chk("t1_count", int'(if_ov.matchCount), 1);
        chk("t1_shift", int'(if_ov.shiftOut), 4'b1011);
        idle(1);
        chk("t1_pulse_end", int'(if_ov.match), 0);

        // Overlap vs non-overlap on 1011011.
        do_clear(1'b0, 1'b0);
        bits_in(16'b1011, 4);
        chk("t2_no_first", int'(if_no.match), 1);
        bits_in(16'b011, 3);
        chk("t2_ov_match7", int'(if_ov.match), 1);
        chk("t2_no_match7", int'(if_no.match), 0);
        chk("t2_ov_count", int'(if_ov.matchCount), 2);
        chk("t2_no_count", int'(if_no.matchCount), 1);

        // Gaps in dValid are ignored.
        do_clear(1'b0, 1'b0);
        bits_in(16'b10, 2);
        idle(3);
        chk("t3_shift_hold", int'(if_ov.shiftOut), 4'b0010);
        bits_in(16'b11, 2);
        chk("t3_match", int'(if_no.match), 1);
        chk("t3_shift", int'(if_ov.shiftOut), 4'b1011);

        // Saturation of the 2-bit counter over five patterns.
        do_clear(1'b0, 1'b0);
        pulses = 0;
        for (int r = 1; r <= 5; r++) begin
            bits_in(16'b1011, 4);
            if (if_no.match) pulses++;
            if (r == 2) chk("t4_sat_before", int'(if_no.countSat), 0);
            if (r == 3) chk("t4_sat_at3", int'(if_no.countSat), 1);
        end
        chk("t4_pulses", pulses, 5);
        chk("t4_no_count", int'(if_no.matchCount), 3);
        chk("t4_ov_count", int'(if_ov.matchCount), 5);

        // Clear beats a simultaneous valid bit.
        do_clear(1'b0, 1'b0);
        bits_in(16'b101, 3);
        do_clear(1'b1, 1'b1);
        chk("t5_shift", int'(if_ov.shiftOut), 0);
        chk("t5_match", int'(if_ov.match), 0);
        bits_in(16'b1011, 4);
        chk("t5_match_after", int'(if_no.match), 1);
        chk("t5_count", int'(if_ov.matchCount), 1);

        // Asynchronous reset between edges discards everything.
        do_clear(1'b0, 1'b0);
        bits_in(16'b10111011, 8);
        chk("t6_pre_count", int'(if_ov.matchCount), 2);
        @(posedge clk);
        #2 resetBar = 1'b0;
        #1;
        chk("t6_async_shift", int'(if_ov.shiftOut), 0);
        chk("t6_async_count", int'(if_ov.matchCount), 0);
        chk("t6_async_count_no", int'(if_no.matchCount), 0);
        @(negedge clk);
        resetBar = 1'b1;
        bit_in(1'b1);
        chk("t6_single_one", int'(if_ov.match), 0);
        bits_in(16'b011, 3);
        chk("t6_match", int'(if_ov.match), 1);
        chk("t6_count", int'(if_no.matchCount), 1);

        idle(2);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
